// File: rtl/adc_dac_loop_pkg.sv
// Shared constants for the ADC-to-DAC calibration loop: CFG word map,
// Q16.16 fraction width and GPIO status bit positions.
package adc_dac_loop_pkg;

    localparam int ADC_GAIN_IDX   = 0;
    localparam int ADC_OFFSET_IDX = 1;
    localparam int DAC_GAIN_IDX   = 2;
    localparam int DAC_OFFSET_IDX = 3;
    localparam int CFG_USED_WORDS = 4;

    localparam int FRAC_BITS = 16;

    localparam int GP_RUN_BIT  = 31;
    localparam int GP_SAT_BIT  = 30;
    localparam int GP_DACA_LSB = 16;

endpackage

// File: rtl/adc_dac_loop_scale.sv
// Signed Q16.16 multiply-add with round-half-up and one register stage.
// The result keeps every integer bit, so chained stages never wrap.
module fp_scale_round
    import adc_dac_loop_pkg::*;
#(
    parameter int IN_WIDTH  = 12,
    parameter int FP_WIDTH  = 32,
    parameter int OUT_WIDTH = IN_WIDTH + FP_WIDTH + 1 - FRAC_BITS
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_valid,
    input  logic [IN_WIDTH-1:0]  i_data,
    input  logic [FP_WIDTH-1:0]  i_gain,
    input  logic [FP_WIDTH-1:0]  i_offset,
    output logic                 o_valid,
    output logic [OUT_WIDTH-1:0] o_data
);

    localparam int SUM_WIDTH = OUT_WIDTH + FRAC_BITS;
    localparam logic signed [SUM_WIDTH-1:0] ROUND_HALF = SUM_WIDTH'(1) <<< (FRAC_BITS - 1);

    logic signed [SUM_WIDTH-1:0] w_dataExt;
    logic signed [SUM_WIDTH-1:0] w_gainExt;
    logic signed [SUM_WIDTH-1:0] w_offsetExt;
    logic signed [SUM_WIDTH-1:0] w_product;
    logic signed [SUM_WIDTH-1:0] w_sum;
    logic [OUT_WIDTH-1:0]        w_result;
    logic [FRAC_BITS-1:0]        w_unusedFrac;

    logic                 r_valid;
    logic [OUT_WIDTH-1:0] r_data;

    assign w_dataExt   = {{(SUM_WIDTH - IN_WIDTH){i_data[IN_WIDTH-1]}}, i_data};
    assign w_gainExt   = {{(SUM_WIDTH - FP_WIDTH){i_gain[FP_WIDTH-1]}}, i_gain};
    assign w_offsetExt = {{(SUM_WIDTH - FP_WIDTH){i_offset[FP_WIDTH-1]}}, i_offset};

    assign w_product = w_dataExt * w_gainExt;
    assign w_sum     = w_product + w_offsetExt + ROUND_HALF;

    // Dropping the fraction bits is the arithmetic shift right by FRAC_BITS.
    assign {w_result, w_unusedFrac} = w_sum;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= w_result;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/adc_dac_loop.sv
// Closed-loop ADC block averager with two Q16.16 calibration stages feeding
// DAC A, the raw scaled average on DAC B, and a GPIO status word.
module adc_dac_loop
    import adc_dac_loop_pkg::*;
#(
    parameter int FP_WIDTH   = 32,
    parameter int ADC_WIDTH  = 12,
    parameter int DAC_WIDTH  = 14,
    parameter int GPIO_WIDTH = 32,
    parameter int AVG_LOG2   = 10
) (
    input  logic                  ADC_CLK,
    input  logic                  ADC_RSTN,
    input  logic [1023:0]         CFG_IN,
    input  logic [ADC_WIDTH-1:0]  ADC_DATA_IN,
    input  logic [GPIO_WIDTH-1:0] GP_IN,
    output logic [GPIO_WIDTH-1:0] GP_OUT,
    output logic                  DONE,
    output logic [DAC_WIDTH-1:0]  DACA_CODE_OUT,
    output logic [DAC_WIDTH-1:0]  DACB_CODE_OUT
);

    localparam int ACC_WIDTH = ADC_WIDTH + AVG_LOG2;
    localparam int DAC_SHIFT = DAC_WIDTH - ADC_WIDTH;
    localparam int C_WIDTH   = ADC_WIDTH + FP_WIDTH + 1 - FRAC_BITS;
    localparam int D_WIDTH   = C_WIDTH + FP_WIDTH + 1 - FRAC_BITS;
    localparam int DS_WIDTH  = D_WIDTH + DAC_SHIFT;
    localparam logic signed [DS_WIDTH-1:0] DAC_MAX = (DS_WIDTH'(1) <<< (DAC_WIDTH - 1)) - DS_WIDTH'(1);
    localparam logic signed [DS_WIDTH-1:0] DAC_MIN = ~DAC_MAX;

    logic                       w_run;
    logic                       w_lastSample;
    logic [ACC_WIDTH-1:0]       w_sampleExt;
    logic [ACC_WIDTH-1:0]       w_accNext;
    logic                       w_cValid;
    logic [C_WIDTH-1:0]         w_c;
    logic                       w_dValid;
    logic [D_WIDTH-1:0]         w_d;
    logic signed [DS_WIDTH-1:0] w_dShifted;
    logic [DAC_WIDTH-1:0]       w_dacaNext;
    logic                       w_saturate;
    logic [GP_RUN_BIT-1:0]      w_unusedGp;
    logic [1023:CFG_USED_WORDS*FP_WIDTH] w_unusedCfg;

    logic [ACC_WIDTH-1:0] r_acc;
    logic [AVG_LOG2-1:0]  r_count;
    logic [ADC_WIDTH-1:0] r_avg;
    logic                 r_avgValid;
    logic                 r_run;
    logic                 r_done;
    logic                 r_sat;
    logic [DAC_WIDTH-1:0] r_daca;
    logic [DAC_WIDTH-1:0] r_dacb;
    logic [ADC_WIDTH-1:0] r_gpAvg;

    assign w_run        = GP_IN[GP_RUN_BIT];
    assign w_unusedGp   = GP_IN[GP_RUN_BIT-1:0];
    assign w_unusedCfg  = CFG_IN[1023:CFG_USED_WORDS*FP_WIDTH];
    assign w_sampleExt  = {{AVG_LOG2{ADC_DATA_IN[ADC_WIDTH-1]}}, ADC_DATA_IN};
    assign w_accNext    = r_acc + w_sampleExt;
    assign w_lastSample = (r_count == {AVG_LOG2{1'b1}});

    // The upper ADC_WIDTH bits of the final sum are the floor average; the
    // accumulator restarts empty so the next sample opens the next block.
    always_ff @(posedge ADC_CLK) begin
        if (!ADC_RSTN) begin
            r_acc      <= '0;
            r_count    <= '0;
            r_avg      <= '0;
            r_avgValid <= 1'b0;
            r_run      <= 1'b0;
        end else begin
            r_run      <= w_run;
            r_avgValid <= 1'b0;
            if (!w_run) begin
                r_acc   <= '0;
                r_count <= '0;
            end else if (w_lastSample) begin
                r_acc      <= '0;
                r_count    <= '0;
                r_avg      <= w_accNext[ACC_WIDTH-1:AVG_LOG2];
                r_avgValid <= 1'b1;
            end else begin
                r_acc   <= w_accNext;
                r_count <= r_count + AVG_LOG2'(1);
            end
        end
    end

    // Valids are gated by RUN so dropping RUN flushes any update in flight.
    fp_scale_round #(
        .IN_WIDTH (ADC_WIDTH),
        .FP_WIDTH (FP_WIDTH),
        .OUT_WIDTH(C_WIDTH)
    ) u_adcCal (
        .i_clk   (ADC_CLK),
        .i_rstn  (ADC_RSTN),
        .i_valid (r_avgValid & w_run),
        .i_data  (r_avg),
        .i_gain  (CFG_IN[ADC_GAIN_IDX*FP_WIDTH +: FP_WIDTH]),
        .i_offset(CFG_IN[ADC_OFFSET_IDX*FP_WIDTH +: FP_WIDTH]),
        .o_valid (w_cValid),
        .o_data  (w_c)
    );

    fp_scale_round #(
        .IN_WIDTH (C_WIDTH),
        .FP_WIDTH (FP_WIDTH),
        .OUT_WIDTH(D_WIDTH)
    ) u_dacCal (
        .i_clk   (ADC_CLK),
        .i_rstn  (ADC_RSTN),
        .i_valid (w_cValid & w_run),
        .i_data  (w_c),
        .i_gain  (CFG_IN[DAC_GAIN_IDX*FP_WIDTH +: FP_WIDTH]),
        .i_offset(CFG_IN[DAC_OFFSET_IDX*FP_WIDTH +: FP_WIDTH]),
        .o_valid (w_dValid),
        .o_data  (w_d)
    );

    assign w_dShifted = {w_d, {DAC_SHIFT{1'b0}}};

    always_comb begin
        w_dacaNext = w_dShifted[DAC_WIDTH-1:0];
        w_saturate = 1'b0;
        if (w_dShifted > DAC_MAX) begin
            w_dacaNext = DAC_MAX[DAC_WIDTH-1:0];
            w_saturate = 1'b1;
        end else if (w_dShifted < DAC_MIN) begin
            w_dacaNext = DAC_MIN[DAC_WIDTH-1:0];
            w_saturate = 1'b1;
        end
    end

    // The saturation flag is sticky for the whole run session.
    always_ff @(posedge ADC_CLK) begin
        if (!ADC_RSTN) begin
            r_done  <= 1'b0;
            r_sat   <= 1'b0;
            r_daca  <= '0;
            r_dacb  <= '0;
            r_gpAvg <= '0;
        end else begin
            r_done <= 1'b0;
            if (!w_run) begin
                r_sat <= 1'b0;
            end
            if (w_dValid && w_run) begin
                r_done  <= 1'b1;
                r_daca  <= w_dacaNext;
                r_dacb  <= {r_avg, {DAC_SHIFT{1'b0}}};
                r_gpAvg <= r_avg;
                if (w_saturate) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        GP_OUT = '0;
        GP_OUT[ADC_WIDTH-1:0] = r_gpAvg;
        GP_OUT[GP_DACA_LSB +: DAC_WIDTH] = r_daca;
        GP_OUT[GP_SAT_BIT] = r_sat;
        GP_OUT[GP_RUN_BIT] = r_run;
    end

    assign DONE          = r_done;
    assign DACA_CODE_OUT = r_daca;
    assign DACB_CODE_OUT = r_dacb;

endmodule

// File: tb/tb_adc_dac_loop.sv
// Self-checking bench for adc_dac_loop: constant-input vector table, a
// scoreboard fed by a block-averaging model, and run/reset control sequences.
module tb_adc_dac_loop;

    localparam int BLOCK   = 1024;
    localparam int LATENCY = 3;
    localparam int TIMEOUT = 3000;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic [1023:0] cfg  = '0;
    logic [11:0]   adc  = '0;
    logic [31:0]   gpIn = '0;
    logic [31:0]   gpOut;
    logic          done;
    logic [13:0]   daca;
    logic [13:0]   dacb;

    always #5 clk = ~clk;

    adc_dac_loop dut (
        .ADC_CLK      (clk),
        .ADC_RSTN     (rstn),
        .CFG_IN       (cfg),
        .ADC_DATA_IN  (adc),
        .GP_IN        (gpIn),
        .GP_OUT       (gpOut),
        .DONE         (done),
        .DACA_CODE_OUT(daca),
        .DACB_CODE_OUT(dacb)
    );

    typedef struct {
        int     avg;
        int     daca;
        int     dacb;
        int     mid;
        longint due;
    } exp_t;

    typedef struct {
        int          adcVal;
        logic [31:0] g1;
        logic [31:0] o1;
        logic [31:0] g2;
        logic [31:0] o2;
        int          expAvg;
        int          expDaca;
        int          expDacb;
        logic        expSat;
    } vec_t;

    exp_t   expQ[$];
    vec_t   vecs[4];
    int     checks     = 0;
    int     failures   = 0;
    longint cycle      = 0;
    int     modelSum   = 0;
    int     modelCount = 0;
    int     modelMid   = 0;
    logic signed [31:0] g1 = '0;
    logic signed [31:0] o1 = '0;
    logic signed [31:0] g2 = '0;
    logic signed [31:0] o2 = '0;
    bit     rampMode   = 1'b0;
    int     prevRampDaca = 0;
    int     rampDones  = 0;

    task automatic checkOutput(input string name, input logic signed [63:0] actual,
                               input logic signed [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic run, input int adcVal);
        @(posedge clk);
        #1;
        rstn = r;
        gpIn = {run, 31'($urandom())};
        adc  = adcVal[11:0];
    endtask

    task automatic setCfg(input logic [31:0] ag, input logic [31:0] ao,
                          input logic [31:0] dg, input logic [31:0] dof);
        g1 = ag;
        o1 = ao;
        g2 = dg;
        o2 = dof;
        for (int w = 4; w < 32; w++) cfg[w*32 +: 32] = $urandom();
        cfg[127:0] = {dof, dg, ao, ag};
    endtask

    task automatic waitDone(output longint at);
        at = -1;
        for (int n = 0; n < TIMEOUT; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                at = cycle;
                return;
            end
        end
        checks++;
        failures++;
        $display("[TB] FAIL done_timeout: no DONE within %0d cycles, expected one", TIMEOUT);
    endtask

    function automatic int modelDaca(input int avg);
        longint c;
        longint d;
        longint s;
        c = (longint'(avg) * longint'(g1) + longint'(o1) + 64'sd32768) >>> 16;
        d = (c * longint'(g2) + longint'(o2) + 64'sd32768) >>> 16;
        s = d * 4;
        if (s > 8191) s = 8191;
        else if (s < -8192) s = -8192;
        return int'(s);
    endfunction

    // Reference model: average each 1024-sample RUN block and queue the result.
    always @(posedge clk) begin
        exp_t e;
        cycle++;
        if (!rstn || !gpIn[31]) begin
            modelSum   = 0;
            modelCount = 0;
            expQ.delete();
        end else begin
            modelSum += $signed(adc);
            if (modelCount == BLOCK / 2) modelMid = $signed(adc);
            modelCount++;
            if (modelCount == BLOCK) begin
                e.avg  = modelSum >>> 10;
                e.daca = modelDaca(e.avg);
                e.dacb = e.avg * 4;
                e.mid  = modelMid;
                e.due  = cycle + LATENCY;
                expQ.push_back(e);
                modelSum   = 0;
                modelCount = 0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        int   avgDut;
        if (expQ.size() > 0 && expQ[0].due < cycle) begin
            checks++;
            failures++;
            $display("[TB] FAIL missed_done: DONE=0 at cycle %0d, expected 1", expQ[0].due);
            e = expQ.pop_front();
        end
        if (done === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done: DONE=1 at cycle %0d, expected 0", cycle);
            end else begin
                e = expQ.pop_front();
                avgDut = $signed(gpOut[11:0]);
                checkOutput("sb_done_cycle", cycle, e.due);
                checkOutput("sb_daca", $signed(daca), e.daca);
                checkOutput("sb_dacb", $signed(dacb), e.dacb);
                checkOutput("sb_gp_avg", avgDut, e.avg);
                checkOutput("sb_gp_daca", $signed(gpOut[29:16]), e.daca);
                if (rampMode) begin
                    rampDones++;
                    checkOutput("ramp_avg_near_mid", ((avgDut - e.mid) <= 1 && (e.mid - avgDut) <= 1) ? 1 : 0, 1);
                    checkOutput("ramp_monotonic", ($signed(daca) >= prevRampDaca) ? 1 : 0, 1);
                    prevRampDaca = e.daca;
                end
            end
        end
    end

    initial begin
        longint t;
        longint at1;
        longint at2;
        int     zeroErr;

        vecs[0] = '{100,   32'h00011D8F, 32'hFFFFFBD1, 32'h00010000, 32'h0, 100,   448,   400,   1'b0};
        vecs[1] = '{2047,  32'h00011D8F, 32'hFFFFFBD1, 32'h00010000, 32'h0, 2047,  8191,  8188,  1'b1};
        vecs[2] = '{-2048, 32'h00011D8F, 32'hFFFFFBD1, 32'h00010000, 32'h0, -2048, -8192, -8192, 1'b1};
        vecs[3] = '{-5,    32'h00010000, 32'h00000000, 32'h00010000, 32'h0, -5,    -20,   -20,   1'b0};

        for (int i = 0; i < 5; i++) begin
            setCfg($urandom(), $urandom(), $urandom(), $urandom());
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)));
            @(negedge clk);
            checkOutput("reset_done", done, 0);
            checkOutput("reset_daca", daca, 0);
            checkOutput("reset_dacb", dacb, 0);
            checkOutput("reset_gpout", gpOut, 0);
        end

        for (int v = 0; v < 4; v++) begin
            applyStimulus(1'b1, 1'b0, vecs[v].adcVal);
            setCfg(vecs[v].g1, vecs[v].o1, vecs[v].g2, vecs[v].o2);
            applyStimulus(1'b1, 1'b0, vecs[v].adcVal);
            applyStimulus(1'b1, 1'b1, vecs[v].adcVal);
            t = cycle;
            waitDone(at1);
            checkOutput("vec_first_latency", at1 - t, BLOCK + LATENCY);
            waitDone(at2);
            checkOutput("vec_done_period", at2 - at1, BLOCK);
            checkOutput("vec_daca", $signed(daca), vecs[v].expDaca);
            checkOutput("vec_dacb", $signed(dacb), vecs[v].expDacb);
            checkOutput("vec_gp_avg", $signed(gpOut[11:0]), vecs[v].expAvg);
            checkOutput("vec_gp_daca", $signed(gpOut[29:16]), vecs[v].expDaca);
            checkOutput("vec_gp_sat", gpOut[30], vecs[v].expSat);
            checkOutput("vec_gp_run", gpOut[31], 1);
        end

        setCfg(32'h00011D8F, 32'hFFFFFBD1, 32'h00010000, 32'h0);
        applyStimulus(1'b1, 1'b0, 0);
        prevRampDaca = -100000;
        rampDones    = 0;
        rampMode     = 1'b1;
        for (int k = 0; k < 5 * BLOCK + 8; k++) applyStimulus(1'b1, 1'b1, k / 1026);
        rampMode = 1'b0;
        checkOutput("ramp_done_count", rampDones, 5);

        applyStimulus(1'b1, 1'b0, 100);
        applyStimulus(1'b1, 1'b1, 100);
        waitDone(at1);
        repeat (500) applyStimulus(1'b1, 1'b1, 100);
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0, 100);
        @(negedge clk);
        checkOutput("hold_daca", $signed(daca), 448);
        checkOutput("hold_dacb", $signed(dacb), 400);
        checkOutput("hold_gp_avg", $signed(gpOut[11:0]), 100);
        checkOutput("hold_gp_run", gpOut[31], 0);
        applyStimulus(1'b1, 1'b1, 100);
        t = cycle;
        waitDone(at1);
        checkOutput("rerun_latency", at1 - t, BLOCK + LATENCY);

        repeat (300) applyStimulus(1'b1, 1'b1, 100);
        applyStimulus(1'b0, 1'b1, 100);
        applyStimulus(1'b1, 1'b1, 100);
        t       = cycle;
        at1     = -1;
        zeroErr = 0;
        for (int n = 0; n < TIMEOUT; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                at1 = cycle;
                break;
            end
            if (daca !== 14'd0 || dacb !== 14'd0 || gpOut[30:0] !== 31'd0) zeroErr++;
        end
        checkOutput("reset_outputs_zero", zeroErr, 0);
        checkOutput("reset_restart_latency", at1 - t, BLOCK + LATENCY);
        checkOutput("reset_restart_daca", $signed(daca), 448);

        repeat (4) applyStimulus(1'b1, 1'b0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
